// File: rtl/calc_arith_sequencer.sv
// Multi-cycle Q9.6 fixed-point arithmetic unit: add/sub in one step, shift-add multiply,
// and restoring divide, with saturation and divide-by-zero/illegal-op flags.
module calc_arith_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        ovf,
  output logic        dz,
  output logic        err_op
);

  localparam logic [2:0] OpAdd = 3'b001;
  localparam logic [2:0] OpSub = 3'b010;
  localparam logic [2:0] OpMul = 3'b011;
  localparam logic [2:0] OpDiv = 3'b100;

  typedef enum logic [1:0] {StIdle, StLoad, StExec, StFin} state_e;
  state_e state_q, state_d;

  logic [2:0]  op_q;
  logic [15:0] a_q, b_q;
  logic        sign_q;
  logic [4:0]  cnt_q;
  logic [31:0] acc_q, mcand_q;
  logic [15:0] mb_q, rem_q;
  logic [21:0] quo_q;
  logic [15:0] result_q;
  logic        done_q, ovf_q, dz_q, err_q;

  logic        accept, op_legal, div_zero;
  logic [15:0] mag_a, mag_b;
  logic [16:0] sum, rem_sh;
  logic [15:0] rem_diff;
  logic        div_fit;

  assign accept   = (state_q == StIdle) && start && !abort;
  assign op_legal = (op_q >= OpAdd) && (op_q <= OpDiv);
  assign div_zero = (op_q == OpDiv) && (b_q == 16'h0000);
  assign mag_a    = a_q[15] ? 16'(-a_q) : a_q;
  assign mag_b    = b_q[15] ? 16'(-b_q) : b_q;
  assign sum      = (op_q == OpSub) ? ({a_q[15], a_q} - {b_q[15], b_q})
                                    : ({a_q[15], a_q} + {b_q[15], b_q});
  // Restoring divide: shift next dividend bit into the partial remainder.
  assign rem_sh   = {rem_q, quo_q[21]};
  assign div_fit  = rem_sh >= {1'b0, mb_q};
  assign rem_diff = 16'(rem_sh - {1'b0, mb_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (start) state_d = StLoad;
        StLoad: state_d = (!op_legal || div_zero) ? StFin : StExec;
        StExec: if (cnt_q == 5'd0) state_d = StFin;
        StFin:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  logic        neg;
  logic [25:0] mag;
  logic [15:0] fin_result;
  logic        fin_ovf;

  always_comb begin
    neg        = sign_q;
    mag        = 26'd0;
    fin_result = 16'h0000;
    fin_ovf    = 1'b0;
    case (op_q)
      OpMul:   mag = acc_q[31:6];
      OpDiv:   mag = {4'b0, quo_q};
      default: begin
        neg = acc_q[16];
        mag = {9'b0, acc_q[16] ? 17'(-acc_q[16:0]) : acc_q[16:0]};
      end
    endcase
    if (mag == 26'd0) begin
      fin_result = 16'h0000;
    end else if (neg && mag > 26'd32768) begin
      fin_result = 16'h8000;
      fin_ovf    = 1'b1;
    end else if (!neg && mag > 26'd32767) begin
      fin_result = 16'h7FFF;
      fin_ovf    = 1'b1;
    end else begin
      fin_result = neg ? 16'(-mag[15:0]) : mag[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= 3'b000;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      sign_q   <= 1'b0;
      cnt_q    <= 5'd0;
      acc_q    <= 32'd0;
      mcand_q  <= 32'd0;
      mb_q     <= 16'h0000;
      rem_q    <= 16'h0000;
      quo_q    <= 22'd0;
      result_q <= 16'h0000;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        op_q     <= op;
        a_q      <= a;
        b_q      <= b;
        result_q <= 16'h0000;
        ovf_q    <= 1'b0;
        dz_q     <= 1'b0;
        err_q    <= 1'b0;
      end
      if (!abort) begin
        case (state_q)
          StLoad: begin
            sign_q  <= a_q[15] ^ b_q[15];
            mcand_q <= {16'b0, mag_a};
            mb_q    <= mag_b;
            acc_q   <= 32'd0;
            rem_q   <= 16'h0000;
            quo_q   <= {mag_a, 6'b0};
            cnt_q   <= (op_q == OpMul) ? 5'd15 : (op_q == OpDiv) ? 5'd21 : 5'd0;
          end
          StExec: begin
            if (cnt_q != 5'd0) cnt_q <= cnt_q - 5'd1;
            case (op_q)
              OpMul: begin
                if (mb_q[0]) acc_q <= acc_q + mcand_q;
                mcand_q <= mcand_q << 1;
                mb_q    <= mb_q >> 1;
              end
              OpDiv: begin
                rem_q <= div_fit ? rem_diff : rem_sh[15:0];
                quo_q <= {quo_q[20:0], div_fit};
              end
              default: acc_q <= {{15{sum[16]}}, sum};
            endcase
          end
          StFin: begin
            done_q <= 1'b1;
            if (!op_legal) begin
              err_q    <= 1'b1;
              result_q <= 16'h0000;
            end else if (div_zero) begin
              dz_q     <= 1'b1;
              result_q <= 16'h0000;
            end else begin
              result_q <= fin_result;
              ovf_q    <= fin_ovf;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;
  assign dz     = dz_q;
  assign err_op = err_q;

endmodule

// File: tb/tb_calc_arith_sequencer.sv
// Bench for calc_arith_sequencer: directed vector table, corner-case sequences, and random
// operations against a plain-arithmetic reference model.
module tb_calc_arith_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [2:0]  op;
  logic [15:0] a, b;
  logic        busy, done, ovf, dz, err_op;
  logic [15:0] result;

  int n_checks = 0;
  int n_errors = 0;

  calc_arith_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf),
    .dz     (dz),
    .err_op (err_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        ovf;
    logic        dz;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: exact rational semantics of each op, then truncation and saturation.
  task automatic model(input logic [2:0] mop, input logic [15:0] ma, input logic [15:0] mb,
                       output logic [15:0] r, output logic o, output logic z,
                       output logic e, output int lat);
    longint sa, sb, t, aa, ab, m;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    aa = (sa < 0) ? -sa : sa;
    ab = (sb < 0) ? -sb : sb;
    r = 16'h0000; o = 1'b0; z = 1'b0; e = 1'b0; t = 0;
    if (mop < 3'd1 || mop > 3'd4) begin
      e = 1'b1; lat = 2;
    end else if (mop == 3'd4 && mb == 16'h0000) begin
      z = 1'b1; lat = 2;
    end else begin
      case (mop)
        3'd1: begin t = sa + sb; lat = 3; end
        3'd2: begin t = sa - sb; lat = 3; end
        3'd3: begin m = (aa * ab) / 64; t = ((sa < 0) != (sb < 0)) ? -m : m; lat = 18; end
        default: begin m = (aa * 64) / ab; t = ((sa < 0) != (sb < 0)) ? -m : m; lat = 24; end
      endcase
      if (t > 32767) begin r = 16'h7FFF; o = 1'b1; end
      else if (t < -32768) begin r = 16'h8000; o = 1'b1; end
      else r = t[15:0];
    end
  endtask

  // Issue one op; poke_cycle>0 re-pulses start (with other operands) before that edge.
  task automatic do_op(input logic [2:0] vop, input logic [15:0] va, input logic [15:0] vb,
                       input int poke_cycle, output int lat);
    @(negedge clk);
    start = 1'b1; op = vop; a = va; b = vb;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("result_cleared_on_accept", result, 0);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      if (n == poke_cycle) begin
        @(negedge clk);
        start = 1'b1; op = 3'b001; a = 16'h0001; b = 16'h0001;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] er, input logic eo,
                              input logic ez, input logic ee, input int el, input int lat);
    chk({tag, "_latency"}, lat, el);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_result"}, result, er);
    chk({tag, "_ovf"}, ovf, eo);
    chk({tag, "_dz"}, dz, ez);
    chk({tag, "_err_op"}, err_op, ee);
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_result_held"}, result, er);
  endtask

  initial begin
    int lat, pulses;
    logic [15:0] er;
    logic eo, ez, ee;
    int el;

    vecs[0]  = '{3'b001, 16'h0060, 16'h0090, 16'h00F0, 1'b0, 1'b0, 1'b0, 3};
    vecs[1]  = '{3'b011, 16'h00A0, 16'h0100, 16'h0280, 1'b0, 1'b0, 1'b0, 18};
    vecs[2]  = '{3'b011, 16'hFF40, 16'h0080, 16'hFE80, 1'b0, 1'b0, 1'b0, 18};
    vecs[3]  = '{3'b100, 16'h01E0, 16'h00A0, 16'h00C0, 1'b0, 1'b0, 1'b0, 24};
    vecs[4]  = '{3'b100, 16'h01E0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 2};
    vecs[5]  = '{3'b001, 16'h7D00, 16'h0500, 16'h7FFF, 1'b1, 1'b0, 1'b0, 3};
    vecs[6]  = '{3'b111, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0, 1'b1, 2};
    vecs[7]  = '{3'b000, 16'h0040, 16'h0040, 16'h0000, 1'b0, 1'b0, 1'b1, 2};
    vecs[8]  = '{3'b010, 16'h8000, 16'h0040, 16'h8000, 1'b1, 1'b0, 1'b0, 3};
    vecs[9]  = '{3'b011, 16'h8000, 16'h0040, 16'h8000, 1'b0, 1'b0, 1'b0, 18};
    vecs[10] = '{3'b010, 16'h0040, 16'h0040, 16'h0000, 1'b0, 1'b0, 1'b0, 3};
    vecs[11] = '{3'b100, 16'hFF40, 16'h0080, 16'hFFA0, 1'b0, 1'b0, 1'b0, 24};
    vecs[12] = '{3'b011, 16'h8000, 16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0, 18};
    vecs[13] = '{3'b011, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 18};
    vecs[14] = '{3'b100, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b0, 24};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; op = 3'b000; a = 16'h0000; b = 16'h0000;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    chk("reset_flags", {ovf, dz, err_op}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, lat);
      check_result($sformatf("vec%0d", i), vecs[i].res, vecs[i].ovf, vecs[i].dz, vecs[i].err,
                   vecs[i].lat, lat);
    end

    // Restart during busy is ignored; product unaffected.
    do_op(3'b011, 16'h00A0, 16'h0100, 5, lat);
    check_result("mul_restart_ignored", 16'h0280, 1'b0, 1'b0, 1'b0, 18, lat);

    // start during the done cycle is accepted on the very next edge.
    do_op(3'b001, 16'h0060, 16'h0090, 0, lat);
    chk("b2b_latency", lat, 3);
    @(negedge clk);
    start = 1'b1; op = 3'b010; a = 16'h0100; b = 16'h0040;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_accept_busy", busy, 1);
    chk("b2b_done_cleared", done, 0);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    chk("b2b_second_latency", lat, 3);
    chk("b2b_second_result", result, 16'h00C0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1; op = 3'b011; a = 16'h00A0; b = 16'h0100;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_result", result, 0);
    chk("midreset_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    chk("midreset_no_done", pulses, 0);

    // Abort a fresh divide at cycle 8.
    @(negedge clk);
    start = 1'b1; op = 3'b100; a = 16'h01E0; b = 16'h00A0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    pulses = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    chk("abort_result_kept", result, 0);
    chk("abort_flags_kept", {ovf, dz, err_op}, 0);

    // abort beats start in IDLE.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; op = 3'b001;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("abort_priority_busy", busy, 0);

    for (int i = 0; i < 150; i++) begin
      logic [2:0]  rop;
      logic [15:0] ra, rb;
      int sel;
      sel = $urandom_range(0, 11);
      rop = (sel < 8) ? 3'(sel) : 3'(sel - 7);
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) ra = {{10{ra[15]}}, ra[5:0]};
      model(rop, ra, rb, er, eo, ez, ee, el);
      do_op(rop, ra, rb, 0, lat);
      check_result($sformatf("rand%0d_op%0d_%h_%h", i, rop, ra, rb), er, eo, ez, ee, el, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/calc_arith_sequencer.md
CALC_ARITH_SEQUENCER -- requirements
Module: calc_arith_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Ports (clock and reset first):
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  request an operation; sampled only while busy=0.
- abort  input  1  synchronous cancel of any operation in progress.
- op  input  3  001 ADD, 010 SUB, 011 MUL, 100 DIV; all other codes illegal.
- a  input  16  operand A: two's complement, 6 fraction bits (range -512.0 .. +511.984375).
- b  input  16  operand B, same format as a.
- busy  output  1  high from accept until the done cycle.
- done  output  1  one-cycle completion pulse.
- result  output  16  result, same format as a.
- ovf  output  1  result saturated.
- dz  output  1  divide by zero.
- err_op  output  1  illegal op code.

Function
REQ-003 SHALL accept a request on a rising edge with start=1 and busy=0, latching op, a and b on that edge.
REQ-004 SHALL ignore start while busy=1; latched operands SHALL NOT change.
REQ-005 States: IDLE, LOAD, EXEC, FIN.
- IDLE -> LOAD on accept.
- LOAD -> EXEC normally; LOAD -> FIN on dz or err_op.
- EXEC -> FIN when the iteration count completes.
- FIN -> IDLE always.
REQ-006 LOAD SHALL compute 16-bit operand magnitudes and the result sign (sign(a) XOR sign(b)); -512.0 has magnitude 0x8000.
REQ-007 ADD/SUB: EXEC SHALL take 1 cycle, computing a+b or a-b in 17-bit signed arithmetic.
REQ-008 MUL: EXEC SHALL take 16 cycles of shift-add over the magnitudes, forming a 32-bit product.
- Magnitude result = product >> 6, truncated.
REQ-009 DIV: EXEC SHALL take 22 cycles of restoring division of (|a| << 6) by |b|.
- Quotient is 22 bits, truncated toward zero.
REQ-010 Latency from the accept edge to the edge that raises done:
- ADD/SUB 3.
- MUL 18.
- DIV 24.
- dz or err_op 2.
REQ-011 FIN SHALL apply the sign, register result and flags, and drive done=1 for exactly one cycle.
REQ-012 result and the flags SHALL hold until the next accept, then clear to 0 on that accept edge.
REQ-013 Overflow (true result outside -32768..32767 LSB) SHALL saturate to 0x7FFF (positive) or 0x8000 (negative) with ovf=1.
REQ-014 DIV with b=0 SHALL give result=0x0000 and dz=1; this is detected in LOAD.
REQ-015 An illegal op SHALL give result=0x0000 and err_op=1.
REQ-016 A zero magnitude result SHALL be 0x0000 (no negative zero).
REQ-017 abort=1 SHALL return to IDLE on the next edge.
- busy goes to 0; no done pulse; result and flags keep their prior values.
- abort has priority over start on the same edge.
REQ-018 busy SHALL be 1 in LOAD, EXEC and FIN, and 0 in IDLE.
REQ-019 start=1 in the cycle done=1 SHALL be accepted on the next edge, since FIN -> IDLE precedes the accept.

Reset
REQ-020 rst_n=0 SHALL immediately force:
- state to IDLE;
- busy, done, ovf, dz and err_op to 0;
- result to 0x0000;
- the iteration counter and internal registers to 0.
REQ-021 Reset asserted mid-operation SHALL discard that operation with no done pulse.
REQ-022 Reset deassertion SHALL take effect on the next rising edge; start is honoured from that edge onward.

Verification
REQ-023 ADD a=0x0060 (1.5), b=0x0090 (2.25) -> result=0x00F0 (3.75), done 3 cycles after accept, all flags 0.
REQ-024 MUL a=0x00A0 (2.5), b=0x0100 (4.0) -> result=0x0280 (10.0) at 18 cycles; MUL a=0xFF40 (-3.0), b=0x0080 (2.0) -> result=0xFE80 (-6.0).
REQ-025 DIV a=0x01E0 (7.5), b=0x00A0 (2.5) -> result=0x00C0 (3.0) at 24 cycles; DIV with b=0x0000 -> result=0x0000, dz=1, done at 2 cycles.
REQ-026 ADD a=0x7D00 (500.0), b=0x0500 (20.0) -> result=0x7FFF, ovf=1; op=3'b111 -> err_op=1, result=0x0000.
REQ-027 Start a MUL, then:
- pulse start again at cycle 5 -> ignored, correct product still returned.
- assert rst_n=0 at cycle 10 -> busy=0 and result=0x0000 immediately, no done pulse.
- abort at cycle 8 of a fresh DIV -> IDLE next edge, no done pulse.
